bcd_count_checker: RTL and testbench

- Consumer-side monitor for the two-digit BCD up/down counter bus: count[7:0] (tens in [7:4], ones in [3:0]) plus updown.
- Samples the bus every clk_1Hz edge, converts it to binary and checks that every step is a legal ±1 BCD step with wrap (00↔99).
- Tracks lock/slip state, counts step errors and wrap events.
- Sits beside the counter: on the same clock and reset, reads its outputs directly.

---
 rtl/bcd_pkg.sv | 50 +++++
 rtl/bcd2bin.sv | 25 ++
 rtl/bcd_count_checker.sv | 142 ++++++++++++++
 tb/tb_bcd_count_checker.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// +--------------------------------------------------------------------------+
// | bcd_pkg : shared BCD constants, checker state encoding, +/-1 step helper |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package bcd_pkg;

   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
   localparam logic [7:0] BCD_MAX       = 8'h99;
   localparam logic [7:0] BCD_MIN       = 8'h00;

   typedef enum logic [0:0] {
      ST_UNLOCKED = 1'b0,
      ST_LOCKED   = 1'b1
   } chk_state_t;

   // An undecodable value is returned unchanged, so it can never match a
   // valid sample and the step after a bad sample is always illegal.
   function automatic logic [7:0] bcd_next(input logic [7:0] value, input logic dir);
      logic [3:0] tens;
      logic [3:0] ones;
      logic [7:0] res;
      tens = value[7:4];
      ones = value[3:0];
      res  = value;
      if ((tens <= BCD_MAX_DIGIT) && (ones <= BCD_MAX_DIGIT)) begin
         if (dir) begin
            if (ones == BCD_MAX_DIGIT) begin
               if (tens == BCD_MAX_DIGIT) res = BCD_MIN;
               else                       res = {tens + 4'd1, 4'd0};
            end else begin
               res = {tens, ones + 4'd1};
            end
         end else begin
            if (ones == 4'd0) begin
               if (tens == 4'd0) res = BCD_MAX;
               else              res = {tens - 4'd1, BCD_MAX_DIGIT};
            end else begin
               res = {tens, ones - 4'd1};
            end
         end
      end
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd2bin.sv
// +--------------------------------------------------------------------------+
// | bcd2bin : combinational two-digit BCD to binary, 7'h7F on invalid input  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

import bcd_pkg::*;

module bcd2bin (
   input  logic [7:0] bcd_i,
   output logic [6:0] bin_o,
   output logic       valid_o
);

   logic [7:0] sum_w;

   // tens*10 as (tens<<3)+(tens<<1) keeps this a pair of adders
   assign sum_w   = {1'b0, bcd_i[7:4], 3'b000} + {3'b000, bcd_i[7:4], 1'b0} + {4'b0000, bcd_i[3:0]};
   assign valid_o = (bcd_i[7:4] <= BCD_MAX_DIGIT) && (bcd_i[3:0] <= BCD_MAX_DIGIT);
   assign bin_o   = valid_o ? sum_w[6:0] : 7'h7F;

endmodule

`default_nettype wire

// File: rtl/bcd_count_checker.sv
// +--------------------------------------------------------------------------+
// | bcd_count_checker : lock/slip monitor for a two-digit BCD up/down count  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

import bcd_pkg::*;

module bcd_count_checker #(
   parameter int RELOCK_N = 2,
   parameter int ERR_W    = 8,
   parameter int WRAP_W   = 8
) (
   input  logic              clk_1Hz,
   input  logic              reset,
   input  logic              updown,
   input  logic [7:0]        count_in,
   output logic [6:0]        bin_out,
   output logic              valid,
   output logic              locked,
   output logic              step_err,
   output logic              err_sticky,
   output logic [ERR_W-1:0]  err_count,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_count
);

   localparam logic [3:0] RELOCK_C = 4'(RELOCK_N);

   logic [6:0]        bin_w;
   logic              valid_w;
   logic [7:0]        expected_w;
   logic              legal_w;
   logic              wrap_w;

   chk_state_t        state_q, state_d;
   logic [3:0]        good_q, good_d;
   logic              have_prev_q;
   logic [7:0]        prev_sample_q;
   logic              prev_dir_q;
   logic [6:0]        bin_q;
   logic              valid_q;
   logic              step_err_q, step_err_d;
   logic              sticky_q, sticky_d;
   logic [ERR_W-1:0]  err_count_q, err_count_d;
   logic              wrap_pulse_q, wrap_pulse_d;
   logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;

   bcd2bin u_bcd2bin (
      .bcd_i   (count_in),
      .bin_o   (bin_w),
      .valid_o (valid_w)
   );

   // The reference direction is the one latched with the previous sample,
   // matching the counter which applies updown one step late.
   assign expected_w = bcd_next(prev_sample_q, prev_dir_q);
   assign legal_w    = have_prev_q && valid_w && (count_in == expected_w);
   assign wrap_w     = prev_dir_q ? ((prev_sample_q == BCD_MAX) && (count_in == BCD_MIN))
                                  : ((prev_sample_q == BCD_MIN) && (count_in == BCD_MAX));

   always_comb begin
      state_d      = state_q;
      good_d       = good_q;
      step_err_d   = 1'b0;
      sticky_d     = sticky_q;
      err_count_d  = err_count_q;
      wrap_pulse_d = 1'b0;
      wrap_count_d = wrap_count_q;
      case (state_q)
         ST_UNLOCKED: begin
            if (legal_w) begin
               good_d = good_q + 4'd1;
               if ((good_q + 4'd1) >= RELOCK_C) state_d = ST_LOCKED;
            end else begin
               good_d = 4'd0;
            end
         end
         ST_LOCKED: begin
            if (legal_w) begin
               if (wrap_w) begin
                  wrap_pulse_d = 1'b1;
                  wrap_count_d = wrap_count_q + WRAP_W'(1);
               end
            end else begin
               step_err_d = 1'b1;
               sticky_d   = 1'b1;
               if (err_count_q != {ERR_W{1'b1}}) err_count_d = err_count_q + ERR_W'(1);
               good_d     = 4'd0;
               state_d    = ST_UNLOCKED;
            end
         end
         default: begin
            state_d = ST_UNLOCKED;
            good_d  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk_1Hz or posedge reset) begin
      if (reset) begin
         state_q       <= ST_UNLOCKED;
         good_q        <= 4'd0;
         have_prev_q   <= 1'b0;
         prev_sample_q <= 8'h00;
         prev_dir_q    <= 1'b0;
         bin_q         <= 7'd0;
         valid_q       <= 1'b0;
         step_err_q    <= 1'b0;
         sticky_q      <= 1'b0;
         err_count_q   <= '0;
         wrap_pulse_q  <= 1'b0;
         wrap_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         good_q        <= good_d;
         have_prev_q   <= 1'b1;
         prev_sample_q <= count_in;
         prev_dir_q    <= updown;
         bin_q         <= bin_w;
         valid_q       <= valid_w;
         step_err_q    <= step_err_d;
         sticky_q      <= sticky_d;
         err_count_q   <= err_count_d;
         wrap_pulse_q  <= wrap_pulse_d;
         wrap_count_q  <= wrap_count_d;
      end
   end

   assign bin_out    = bin_q;
   assign valid      = valid_q;
   assign locked     = (state_q == ST_LOCKED);
   assign step_err   = step_err_q;
   assign err_sticky = sticky_q;
   assign err_count  = err_count_q;
   assign wrap_pulse = wrap_pulse_q;
   assign wrap_count = wrap_count_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_count_checker.sv
// +--------------------------------------------------------------------------+
// | tb_bcd_count_checker : scoreboard bench for bcd_count_checker            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_bcd_count_checker;

   localparam int RELOCK_N = 2;

   logic       clk_1Hz = 1'b0;
   logic       reset   = 1'b1;
   logic       updown  = 1'b1;
   logic [7:0] count_in = 8'h00;
   logic [6:0] bin_out;
   logic       valid, locked, step_err, err_sticky, wrap_pulse;
   logic [7:0] err_count, wrap_count;

   bcd_count_checker #(.RELOCK_N(RELOCK_N), .ERR_W(8), .WRAP_W(8)) dut (
      .clk_1Hz    (clk_1Hz),
      .reset      (reset),
      .updown     (updown),
      .count_in   (count_in),
      .bin_out    (bin_out),
      .valid      (valid),
      .locked     (locked),
      .step_err   (step_err),
      .err_sticky (err_sticky),
      .err_count  (err_count),
      .wrap_pulse (wrap_pulse),
      .wrap_count (wrap_count)
   );

   always #5 clk_1Hz = ~clk_1Hz;

   typedef struct {
      logic [6:0] bin;
      logic       valid;
      logic       locked;
      logic       step_err;
      logic       sticky;
      logic [7:0] err_count;
      logic       wrap_pulse;
      logic [7:0] wrap_count;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model in plain binary arithmetic
   logic       m_have, m_dir, m_locked, m_sticky;
   logic [7:0] m_prev;
   int         m_good, m_err, m_wrap;

   function automatic logic dig_ok(input logic [7:0] x);
      return (x[7:4] <= 4'd9) && (x[3:0] <= 4'd9);
   endfunction

   function automatic int to_bin(input logic [7:0] x);
      return int'(x[7:4]) * 10 + int'(x[3:0]);
   endfunction

   function automatic logic [7:0] to_bcd(input int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   task automatic model_reset();
      m_have = 0; m_dir = 0; m_locked = 0; m_sticky = 0;
      m_prev = 8'h00; m_good = 0; m_err = 0; m_wrap = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_push(input logic [7:0] s, input logic d);
      exp_t e;
      int   want;
      logic legal, wrap;
      want  = m_dir ? (to_bin(m_prev) + 1) % 100 : (to_bin(m_prev) + 99) % 100;
      legal = m_have && dig_ok(s) && dig_ok(m_prev) && (to_bin(s) == want);
      wrap  = legal && (m_dir ? (to_bin(m_prev) == 99 && to_bin(s) == 0)
                              : (to_bin(m_prev) == 0 && to_bin(s) == 99));
      e.step_err   = m_locked && !legal;
      e.wrap_pulse = m_locked && wrap;
      if (m_locked) begin
         if (!legal) begin
            m_locked = 0; m_good = 0; m_sticky = 1;
            if (m_err < 255) m_err++;
         end else if (wrap) begin
            m_wrap = (m_wrap + 1) % 256;
         end
      end else if (legal) begin
         m_good++;
         if (m_good >= RELOCK_N) m_locked = 1;
      end else begin
         m_good = 0;
      end
      e.bin        = dig_ok(s) ? 7'(to_bin(s)) : 7'h7F;
      e.valid      = dig_ok(s);
      e.locked     = m_locked;
      e.sticky     = m_sticky;
      e.err_count  = 8'(m_err);
      e.wrap_count = 8'(m_wrap);
      m_have = 1; m_prev = s; m_dir = d;
      sb_q.push_back(e);
   endtask

   task automatic step(input logic [7:0] v, input logic d);
      exp_t e;
      count_in = v;
      updown   = d;
      model_push(v, d);
      @(posedge clk_1Hz);
      @(negedge clk_1Hz);
      checks++;
      assert (sb_q.size() > 0) else begin
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("bin_out",    32'(bin_out),    32'(e.bin));
         chk("valid",      32'(valid),      32'(e.valid));
         chk("locked",     32'(locked),     32'(e.locked));
         chk("step_err",   32'(step_err),   32'(e.step_err));
         chk("err_sticky", 32'(err_sticky), 32'(e.sticky));
         chk("err_count",  32'(err_count),  32'(e.err_count));
         chk("wrap_pulse", 32'(wrap_pulse), 32'(e.wrap_pulse));
         chk("wrap_count", 32'(wrap_count), 32'(e.wrap_count));
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_bin"},    32'(bin_out),    0);
      chk({tag, "_valid"},  32'(valid),      0);
      chk({tag, "_locked"}, 32'(locked),     0);
      chk({tag, "_err"},    32'(step_err),   0);
      chk({tag, "_sticky"}, 32'(err_sticky), 0);
      chk({tag, "_errcnt"}, 32'(err_count),  0);
      chk({tag, "_wrap"},   32'(wrap_pulse), 0);
      chk({tag, "_wrapcnt"},32'(wrap_count), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b;
      model_reset();
      @(posedge clk_1Hz);
      @(negedge clk_1Hz);
      chk_all_zero("reset");
      reset = 1'b0;

      // 1: count up from 00, lock on 02
      step(8'h00, 1); step(8'h01, 1); step(8'h02, 1);
      chk("t1_locked_at_02", 32'(locked), 1);
      step(8'h03, 1);

      // 2: jump, relock, then wrap 99 -> 00 while locked
      step(8'h96, 1); step(8'h97, 1); step(8'h98, 1); step(8'h99, 1);
      step(8'h00, 1);
      chk("t2_wrap_pulse", 32'(wrap_pulse), 1);
      step(8'h01, 1);
      chk("t2_wrap_count", 32'(wrap_count), 1);

      // 3: down through 00 -> 99, then a direction flip
      step(8'h02, 0); step(8'h01, 0); step(8'h00, 0); step(8'h99, 0);
      step(8'h45, 1); step(8'h46, 1); step(8'h47, 0); step(8'h46, 0); step(8'h45, 0);
      chk("t3_no_err_on_flip", 32'(step_err), 0);

      // 4: skipped value while locked, relock after two legal steps
      step(8'h35, 1); step(8'h36, 1); step(8'h37, 1);
      step(8'h39, 1);
      chk("t4_step_err", 32'(step_err), 1);
      step(8'h40, 1); step(8'h41, 1);
      chk("t4_relocked", 32'(locked), 1);

      // 5: invalid digit
      step(8'h42, 1);
      step(8'h3A, 1);
      chk("t5_bin_7f", 32'(bin_out), 32'h7F);
      step(8'h40, 1); step(8'h41, 1); step(8'h42, 1);

      // 6: drive the error counter into saturation
      for (int i = 0; i < 300; i++) begin
         b = to_bin(m_prev);
         step(to_bcd((b + 5) % 100), 1);
         step(to_bcd((b + 6) % 100), 1);
         step(to_bcd((b + 7) % 100), 1);
      end
      chk("t6_err_saturated", 32'(err_count), 32'd255);
      b = to_bin(m_prev);
      step(to_bcd((b + 1) % 100), 1);
      step(to_bcd((b + 2) % 100), 1);

      // asynchronous reset between edges clears everything at once
      reset = 1'b1;
      #1;
      chk_all_zero("midreset");
      model_reset();
      sb_q.delete();
      @(posedge clk_1Hz);
      @(negedge clk_1Hz);
      reset = 1'b0;
      step(8'h17, 1);
      chk("t6_first_unchecked", 32'(step_err), 0);
      step(8'h18, 1); step(8'h19, 1); step(8'h20, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
